warp_scheduler: RTL and testbench

- Per-core controller that sequences the per-warp scalar register files and shared datapath through the warp pipeline (fetch, decode, register read, memory wait, execute, writeback).
- Round-robin time-multiplexes one issue slot among NUM_WARPS warps and drives each register file's enable and the broadcast warp_state.
- Handshakes with the instruction fetcher and LSU, and tracks per-warp retirement to signal kernel completion.

---
 rtl/warp_scheduler_if.sv | 68 ++++++
 rtl/warp_scheduler.sv | 168 ++++++++++++++++
 tb/tb_warp_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_if.sv
// Package and interface shared by the warp scheduler and its environment.
// The package holds the broadcast pipeline-stage type. The interface bundles
// the launch, fetch, decode, LSU and status signals between the scheduler
// (master) and the rest of the core (slave).

package warp_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      REQUEST = 3'd3,
      WAIT    = 3'd4,
      EXECUTE = 3'd5,
      UPDATE  = 3'd6,
      DONE    = 3'd7
   } warp_state_t;

endpackage

interface warp_scheduler_if #(
   parameter int NUM_WARPS      = 4,
   parameter int WARP_IDX_WIDTH = $clog2(NUM_WARPS),
   parameter int COUNT_WIDTH    = 32
);
   import warp_scheduler_pkg::*;

   // Kernel launch
   logic                      start;
   logic [WARP_IDX_WIDTH:0]   num_warps;

   // Per-warp selection and pipeline broadcast
   logic [NUM_WARPS-1:0]      warp_enable;
   logic [WARP_IDX_WIDTH-1:0] current_warp;
   warp_state_t               warp_state;

   // Instruction fetch handshake
   logic                      fetch_req;
   logic                      fetch_valid;

   // Decoder flags
   logic                      decoded_is_mem;
   logic                      decoded_ret;

   // LSU handshake
   logic                      lsu_req;
   logic                      lsu_done;

   // Kernel status
   logic                      busy;
   logic                      done;
   logic [COUNT_WIDTH-1:0]    instr_retired;

   // Scheduler side
   modport master (
      input  start, num_warps, fetch_valid, decoded_is_mem, decoded_ret, lsu_done,
      output warp_enable, current_warp, warp_state, fetch_req, lsu_req,
             busy, done, instr_retired
   );

   // Core / environment side
   modport slave (
      output start, num_warps, fetch_valid, decoded_is_mem, decoded_ret, lsu_done,
      input  warp_enable, current_warp, warp_state, fetch_req, lsu_req,
             busy, done, instr_retired
   );

endinterface

// File: rtl/warp_scheduler.sv
// Warp scheduler: round-robin time-multiplexes one issue slot among the
// launched warps. It steps the selected warp through fetch, decode, register
// read, optional memory wait, execute and writeback, and tracks which warps
// have retired so it can signal kernel completion. All outputs are registered.

module warp_scheduler
   import warp_scheduler_pkg::*;
#(
   parameter int NUM_WARPS      = 4,
   parameter int WARP_IDX_WIDTH = $clog2(NUM_WARPS),
   parameter int COUNT_WIDTH    = 32
) (
   input  logic             clk,
   input  logic             reset,
   warp_scheduler_if.master bus
);

   warp_state_t               state;
   logic [WARP_IDX_WIDTH-1:0] cur_warp;
   logic [NUM_WARPS-1:0]      enable_q;
   logic [NUM_WARPS-1:0]      active_mask;
   logic [NUM_WARPS-1:0]      retired_mask;
   logic                      fetch_req_q;
   logic                      lsu_req_q;
   logic                      busy_q;
   logic                      done_q;
   logic [COUNT_WIDTH-1:0]    retired_count;

   logic [NUM_WARPS-1:0]      launch_mask;
   logic [NUM_WARPS-1:0]      retired_next;
   logic [NUM_WARPS-1:0]      eligible;
   logic                      next_found;
   logic [WARP_IDX_WIDTH-1:0] next_warp;
   logic [WARP_IDX_WIDTH-1:0] probe;

   function automatic logic [NUM_WARPS-1:0] onehot(input logic [WARP_IDX_WIDTH-1:0] w);
      logic [NUM_WARPS-1:0] v;
      v    = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   // Warps to launch: low num_warps bits set; bits past NUM_WARPS do not exist,
   // which clamps oversized requests for free.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      launch_mask = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (i < int'(bus.num_warps)) launch_mask[i] = 1'b1;
      end
   end

   // Next warp after the current one in cyclic order, judged against the
   // retired mask as it will be once this instruction's return is recorded.
   // Scanning from the farthest offset down lets the nearest eligible warp win;
   // offset NUM_WARPS wraps to the current warp, so it is considered last.
   always_comb begin
      retired_next = retired_mask;
      if (bus.decoded_ret) retired_next[cur_warp] = 1'b1;
      eligible   = active_mask & ~retired_next;
      next_found = 1'b0;
      next_warp  = cur_warp;
      probe      = cur_warp;
      for (int k = NUM_WARPS; k >= 1; k--) begin
         probe = cur_warp + WARP_IDX_WIDTH'(k);
         if (eligible[probe]) begin
            next_found = 1'b1;
            next_warp  = probe;
         end
      end
   end

   // Pipeline sequencer: state, warp selection, masks and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: async reset clears every flop immediately, so no fetch or LSU
         // request can outlive a mid-kernel reset.
         state         <= IDLE;
         cur_warp      <= '0;
         enable_q      <= '0;
         active_mask   <= '0;
         retired_mask  <= '0;
         fetch_req_q   <= 1'b0;
         lsu_req_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         retired_count <= '0;
      end else begin
         // NOTE: non-blocking assignments so every branch reads pre-edge values.
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  active_mask   <= launch_mask;
                  retired_mask  <= '0;
                  retired_count <= '0;
                  cur_warp      <= '0;
                  if (launch_mask == '0) begin
                     state       <= DONE;
                     enable_q    <= '0;
                     fetch_req_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     state       <= FETCH;
                     enable_q    <= onehot('0);
                     fetch_req_q <= 1'b1;
                     busy_q      <= 1'b1;
                     done_q      <= 1'b0;
                  end
               end
            end

            FETCH: begin
               if (bus.fetch_valid) begin
                  state       <= DECODE;
                  fetch_req_q <= 1'b0;
               end
            end

            DECODE: state <= REQUEST;

            REQUEST: begin
               if (bus.decoded_is_mem) begin
                  state     <= WAIT;
                  lsu_req_q <= 1'b1;
               end else begin
                  state <= EXECUTE;
               end
            end

            WAIT: begin
               lsu_req_q <= 1'b0;
               if (bus.lsu_done) state <= EXECUTE;
            end

            EXECUTE: state <= UPDATE;

            UPDATE: begin
               retired_count <= retired_count + COUNT_WIDTH'(1);
               retired_mask  <= retired_next;
               if (next_found) begin
                  state       <= FETCH;
                  cur_warp    <= next_warp;
                  enable_q    <= onehot(next_warp);
                  fetch_req_q <= 1'b1;
               end else begin
                  state    <= DONE;
                  enable_q <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.warp_state    = state;
   assign bus.current_warp  = cur_warp;
   assign bus.warp_enable   = enable_q;
   assign bus.fetch_req     = fetch_req_q;
   assign bus.lsu_req       = lsu_req_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.instr_retired = retired_count;

endmodule

// File: tb/tb_warp_scheduler.sv
// Testbench for warp_scheduler. Each kernel is planned up front as a list of
// cycles: the expected pipeline stage, warp and retired count for every cycle,
// together with the environment inputs for that cycle (fetch/LSU latencies,
// decoder flags, spurious start pulses). The plan is replayed against the DUT
// and every output is compared on the falling edge.

module tb_warp_scheduler;
   import warp_scheduler_pkg::*;

   localparam int NW = 4;
   localparam int IW = 2;
   localparam int CW = 32;

   logic clk = 1'b0;
   logic reset;

   warp_scheduler_if #(.NUM_WARPS(NW), .WARP_IDX_WIDTH(IW), .COUNT_WIDTH(CW)) bus ();

   warp_scheduler #(.NUM_WARPS(NW), .WARP_IDX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      warp_state_t st;
      int          warp;
      int          cnt;
      bit          first_wait;
      bit          fv;
      bit          mem;
      bit          ret;
      bit          ld;
      bit          start;
      logic [IW:0] nreq;
   } cyc_t;

   cyc_t        plan[$];
   warp_state_t m_state;
   int          m_warp;
   int          m_count;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Cycle entry with don't-care inputs randomised.
   function automatic cyc_t junk(input warp_state_t st, input int warp, input int cnt);
      cyc_t e;
      e.st         = st;
      e.warp       = warp;
      e.cnt        = cnt;
      e.first_wait = 1'b0;
      e.fv         = 1'($urandom);
      e.mem        = 1'($urandom);
      e.ret        = 1'($urandom);
      e.ld         = 1'($urandom);
      e.start      = 1'b0;
      e.nreq       = (IW+1)'($urandom_range(0, 7));
      return e;
   endfunction

   // Mid-kernel entry: start may be pulsed, and must be ignored.
   function automatic cyc_t mid(input warp_state_t st, input int warp, input int cnt, input bit pester);
      cyc_t e;
      e       = junk(st, warp, cnt);
      e.start = pester ? 1'b1 : ($urandom_range(0, 7) == 0);
      return e;
   endfunction

   // Plans one kernel from the scheduling rules: round robin over launched,
   // unretired warps, each instruction walking the pipeline stages.
   task automatic build_plan(input int nreq, input int ninstr[NW], input int mem_mode,
                             input int fd_mode, input int ld_mode, input bit pester);
      int   n, cur, cnt, fd, ld;
      bit   mem, rt, found;
      bit   act[NW];
      bit   gone[NW];
      int   rem[NW];
      cyc_t e;
      n = (nreq > NW) ? NW : nreq;
      plan.delete();
      e       = junk(m_state, m_warp, m_count);
      e.start = 1'b1;
      e.nreq  = (IW+1)'(nreq);
      plan.push_back(e);
      cur = 0;
      cnt = 0;
      for (int i = 0; i < NW; i++) begin
         act[i]  = (i < n);
         gone[i] = 1'b0;
         rem[i]  = (ninstr[i] > 0) ? ninstr[i] : int'($urandom_range(1, 3));
      end
      found = (n > 0);
      while (found) begin
         fd  = (fd_mode < 0) ? int'($urandom_range(0, 2)) : fd_mode;
         ld  = (ld_mode < 0) ? int'($urandom_range(0, 3)) : ld_mode;
         mem = (mem_mode < 0) ? 1'($urandom) : mem_mode[0];
         rem[cur]--;
         rt = (rem[cur] == 0);
         for (int j = 0; j <= fd; j++) begin
            e    = mid(FETCH, cur, cnt, pester);
            e.fv = (j == fd);
            plan.push_back(e);
         end
         e = mid(DECODE, cur, cnt, pester);  e.mem = mem; e.ret = rt; plan.push_back(e);
         e = mid(REQUEST, cur, cnt, pester); e.mem = mem; e.ret = rt; plan.push_back(e);
         if (mem) begin
            for (int j = 0; j <= ld; j++) begin
               e            = mid(WAIT, cur, cnt, pester);
               e.mem        = mem;
               e.ret        = rt;
               e.first_wait = (j == 0);
               e.ld         = (j == ld);
               plan.push_back(e);
            end
         end
         e = mid(EXECUTE, cur, cnt, pester); e.mem = mem; e.ret = rt; plan.push_back(e);
         e = mid(UPDATE, cur, cnt, pester);  e.mem = mem; e.ret = rt; plan.push_back(e);
         cnt++;
         if (rt) gone[cur] = 1'b1;
         found = 1'b0;
         for (int k = 1; k <= NW; k++) begin
            if (!found && act[(cur + k) % NW] && !gone[(cur + k) % NW]) begin
               found = 1'b1;
               cur   = (cur + k) % NW;
            end
         end
      end
      plan.push_back(junk(DONE, cur, cnt));
   endtask

   task automatic check_outputs(input cyc_t e, input string ctx);
      bit idle_like;
      idle_like = (e.st == IDLE) || (e.st == DONE);
      check({ctx, ".state"}, 64'(bus.warp_state), 64'(e.st));
      check({ctx, ".warp"}, 64'(bus.current_warp), 64'(e.warp));
      check({ctx, ".enable"}, 64'(bus.warp_enable), idle_like ? 64'd0 : (64'd1 << e.warp));
      check({ctx, ".fetch_req"}, 64'(bus.fetch_req), 64'(e.st == FETCH));
      check({ctx, ".lsu_req"}, 64'(bus.lsu_req), 64'(e.first_wait));
      check({ctx, ".busy"}, 64'(bus.busy), 64'(!idle_like));
      check({ctx, ".done"}, 64'(bus.done), 64'(e.st == DONE));
      check({ctx, ".retired"}, 64'(bus.instr_retired), 64'(e.cnt));
   endtask

   task automatic drive(input cyc_t e);
      bus.start          = e.start;
      bus.num_warps      = e.nreq;
      bus.fetch_valid    = e.fv;
      bus.decoded_is_mem = e.mem;
      bus.decoded_ret    = e.ret;
      bus.lsu_done       = e.ld;
   endtask

   function automatic int find_abort(input int kind);
      for (int i = 1; i < plan.size(); i++) begin
         if (kind == 1 && plan[i].st == WAIT) return i;
         if (kind == 2 && plan[i].st == FETCH && plan[i-1].st == UPDATE) return i;
      end
      if (kind == 2) begin
         for (int i = 1; i < plan.size(); i++) if (plan[i].st == FETCH) return i;
      end
      return -1;
   endfunction

   // Replays the plan; optionally asserts reset mid-cycle at entry abort_at.
   task automatic run_plan(input int abort_at, input string name);
      cyc_t r;
      for (int i = 0; i < plan.size(); i++) begin
         @(negedge clk);
         check_outputs(plan[i], $sformatf("%s[%0d]", name, i));
         drive(plan[i]);
         if (i == abort_at) begin
            #2 reset = 1'b0;
            #1 r = junk(IDLE, 0, 0);
            check_outputs(r, $sformatf("%s.async_reset", name));
            bus.start = 1'b0;
            #1 reset = 1'b1;
            m_state = IDLE;
            m_warp  = 0;
            m_count = 0;
            return;
         end
      end
      m_state = plan[plan.size()-1].st;
      m_warp  = plan[plan.size()-1].warp;
      m_count = plan[plan.size()-1].cnt;
   endtask

   task automatic kernel(input string name, input int nreq, input int ninstr[NW], input int mem_mode,
                         input int fd_mode, input int ld_mode, input bit pester, input int abort_kind);
      build_plan(nreq, ninstr, mem_mode, fd_mode, ld_mode, pester);
      run_plan((abort_kind == 0) ? -1 : find_abort(abort_kind), name);
   endtask

   initial begin
      cyc_t r;
      int   kind;
      reset = 1'b0;
      drive(junk(IDLE, 0, 0));
      bus.start = 1'b0;
      #3 r = junk(IDLE, 0, 0);
      check_outputs(r, "reset");
      #4 reset = 1'b1;
      m_state = IDLE;
      m_warp  = 0;
      m_count = 0;

      // Single warp, one non-memory returning instruction, fetch one cycle late.
      kernel("one_warp", 1, '{1, 1, 1, 1}, 0, 1, 0, 1'b0, 0);
      // Three warps, three instructions each, rotation 0,1,2.
      kernel("three_warps", 3, '{3, 3, 3, 3}, 0, -1, 0, 1'b0, 0);
      // Memory instruction with four WAIT cycles, then with one.
      kernel("lsu_slow", 1, '{1, 1, 1, 1}, 1, 0, 3, 1'b0, 0);
      kernel("lsu_fast", 1, '{1, 1, 1, 1}, 1, 0, 0, 1'b0, 0);
      // Warp 1 retires first; it must drop out of the rotation.
      kernel("warp1_first", 4, '{3, 1, 3, 3}, 0, 0, 0, 1'b0, 0);
      // Empty launch and clamped launch.
      kernel("zero_warps", 0, '{1, 1, 1, 1}, 0, 0, 0, 1'b0, 0);
      kernel("clamp7", 7, '{2, 2, 2, 2}, 0, 0, 0, 1'b0, 0);
      // start held high through a whole kernel is ignored outside IDLE/DONE.
      kernel("start_spam", 2, '{2, 2, 2, 2}, -1, -1, -1, 1'b1, 0);
      // Reset in WAIT, then in FETCH, then a clean relaunch.
      kernel("abort_wait", 2, '{2, 2, 2, 2}, 1, -1, 3, 1'b0, 1);
      kernel("abort_fetch", 2, '{2, 2, 2, 2}, 0, 1, 0, 1'b0, 2);
      kernel("relaunch", 2, '{1, 2, 1, 1}, -1, -1, -1, 1'b0, 0);

      for (int t = 0; t < 40; t++) begin
         kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         kernel($sformatf("rand%0d", t), int'($urandom_range(0, 7)), '{0, 0, 0, 0},
                (kind == 1) ? 1 : -1, -1, -1, ($urandom_range(0, 3) == 0), kind);
      end

      @(negedge clk);
      r = junk(m_state, m_warp, m_count);
      check_outputs(r, "final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
